obuf: RTL and testbench
=======================

// Module: obuf
// PURPOSE
//   Output-side buffer for the CIM datapath. Captures one full vector of
//   results in a single cycle, then serialises it word by word to the
//   downstream consumer over a valid/ready handshake.
//   It is the counterpart of the input shift buffer: that block assembles
//   a vector from a word stream; this block turns a vector back into one.
// PARAMETERS
//   datatype_size  8  width of one data word in bits
//   fifo_length    5  words per vector (must be >= 2)
// PORTS
//   clk           in   1                            rising-edge clock
//   rst_n         in   1                            async active-low reset
//   i_load        in   1                            parallel-load strobe
//   i_data        in   [datatype_size-1:0] x fifo_length  vector to capture
//   o_load_ready  out  1                            buffer idle, accepts load
//   o_valid       out  1                            o_data holds a valid word
//   i_ready       in   1                            consumer accepts o_data
//   o_data        out  datatype_size                current output word
//   o_last        out  1                            o_data is word fifo_length-1
// BEHAVIOUR
// - Reset, asynchronous on the falling edge of rst_n:
//   - state=IDLE, idx=0, all buffer words=0.
//   - Outputs: o_valid=0, o_last=0, o_data=0, o_load_ready=1.
// - Storage and counter:
//   - buf[0..fifo_length-1] is registered.
//   - idx is a $clog2(fifo_length)-bit counter.
// - FSM, two states:
//   - IDLE:
//     - o_load_ready=1, o_valid=0.
//     - If i_load=1: buf[k] <= i_data[k] for all k, idx <= 0, next state SHIFT.
//   - SHIFT:
//     - o_load_ready=0, o_valid=1, o_data=buf[idx].
//     - o_last = (idx == fifo_length-1).
//     - On handshake (o_valid & i_ready) with o_last=0: idx <= idx+1.
//     - On handshake with o_last=1: idx <= 0, next state IDLE.
//     - Without i_ready: hold idx, o_data and o_last stable. No word is dropped
//       or repeated.
// - Output decode: o_data, o_last and o_valid are decoded from registered
//   state and idx only. There is no combinational path from i_ready or i_load
//   to any output.
// - Latency:
//   - Load accepted at edge N -> word 0 is valid in the cycle after edge N.
//   - With i_ready held at 1, words 0..fifo_length-1 come out on consecutive
//     cycles, and o_load_ready=1 again in the cycle after the last handshake.
//   - Minimum period per vector is fifo_length+1 cycles (one IDLE cycle).
// - Emission order: index 0 first, fifo_length-1 last.
// - Boundary conditions:
//   - i_load while in SHIFT is ignored: buf and idx are unchanged.
//   - i_ready while in IDLE has no effect.
//   - idx never exceeds fifo_length-1. It wraps to 0 only through the
//     last-word handshake.
//   - i_load and i_ready both high in IDLE: the load is taken. There is no
//     handshake in IDLE because o_valid=0.
//   - Reset mid-vector: the vector is discarded and the block restarts in IDLE
//     with the reset values above.
//   - i_data is sampled only on the accepting edge. Later changes to i_data do
//     not affect the words being emitted.
// TESTING
// - Reset check: assert rst_n=0 mid-cycle with no clock.
//   -> o_valid=0, o_load_ready=1, o_data=0, o_last=0 immediately.
// - Basic serialisation: load {10,20,30,40,50} with i_ready=1.
//   -> o_data = 10,20,30,40,50 on 5 consecutive cycles.
//   -> o_last=1 only on 50.
//   -> o_load_ready=1 on the following cycle.
// - Backpressure: load {1,2,3,4,5}; drop i_ready on the cycle showing 3 and
//   hold it low 4 cycles.
//   -> o_data stays 3 and o_valid stays 1.
//   -> Output resumes 3,4,5 once i_ready=1. No duplicate or lost word.
// - Load while busy: during SHIFT of {1..5}, pulse i_load with {9,9,9,9,9}.
//   -> Output is still 1..5 and 9 never appears.
//   -> A following IDLE load of {9,...} emits 9s.
// - Reset mid-vector: assert rst_n=0 while word 2 is presented.
//   -> Reset values apply at once.
//   -> A new load {7,8,9,10,11} after release emits 7..11 from index 0.
// - Back-to-back vectors: two loads at the earliest legal cycles, i_ready=1.
//   -> 5 words, then 1 idle cycle, then 5 words. 11 cycles total.

Source files
------------

// File: rtl/obuf_if.sv
// obuf_if: bundles the load side and the streaming side of the output buffer.
//   i_load        load strobe for a full vector
//   i_data        vector to capture, element k is word k
//   o_load_ready  buffer idle, a load will be accepted
//   o_valid       o_data holds a valid word
//   i_ready       consumer accepts o_data
//   o_data        current output word
//   o_last        o_data is the final word of the vector
// Modports: slave = buffer side, master = producer/consumer side.
interface obuf_if #(
  parameter int datatype_size = 8,
  parameter int fifo_length   = 5
);
  logic                                        i_load;
  logic [fifo_length-1:0][datatype_size-1:0]   i_data;
  logic                                        o_load_ready;
  logic                                        o_valid;
  logic                                        i_ready;
  logic [datatype_size-1:0]                    o_data;
  logic                                        o_last;

  modport slave (
    input  i_load, i_data, i_ready,
    output o_load_ready, o_valid, o_data, o_last
  );

  modport master (
    output i_load, i_data, i_ready,
    input  o_load_ready, o_valid, o_data, o_last
  );
endinterface

// File: rtl/obuf.sv
// obuf: output-side vector buffer. Captures a whole vector in one cycle and
// then streams it out word 0 first over a valid/ready handshake.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    obuf_if slave modport (load strobe/vector, stream outputs)
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | buffer empty, o_load_ready=1, waits for i_load
// SHIFT  | presenting r_buf[r_idx], advances on each handshake
module obuf #(
  parameter int datatype_size = 8,
  parameter int fifo_length   = 5
) (
  input  logic  clk,
  input  logic  rst_n,
  obuf_if.slave bus
);

  localparam int                IDX_W    = (fifo_length > 1) ? $clog2(fifo_length) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(fifo_length - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         w_idx_nxt;
  logic [datatype_size-1:0] r_buf [fifo_length];
  logic                     w_load_en;
  logic                     w_at_last;

  assign w_at_last = (r_idx == LAST_IDX);

  // State and index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // i_ready is irrelevant here: nothing is being offered.
        if (bus.i_load) begin
          w_load_en   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // i_load is deliberately ignored while a vector is in flight.
        if (bus.i_ready) begin
          if (w_at_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Vector storage, written only on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < fifo_length; k++) begin
        r_buf[k] <= '0;
      end
    end else if (w_load_en) begin
      for (int k = 0; k < fifo_length; k++) begin
        r_buf[k] <= bus.i_data[k];
      end
    end
  end

  // Outputs come from registered state only, so the consumer never sees a
  // combinational path from its own i_ready. o_data is forced to zero in
  // IDLE so stale words are never visible while o_valid is low.
  assign bus.o_valid      = (r_state == S_SHIFT);
  assign bus.o_load_ready = (r_state == S_IDLE);
  assign bus.o_last       = (r_state == S_SHIFT) && w_at_last;
  assign bus.o_data       = (r_state == S_SHIFT) ? r_buf[r_idx] : '0;

endmodule

// File: tb/tb_obuf.sv
// tb_obuf: self-checking bench for obuf. A queue-based model holds the words
// still owed to the consumer; each cycle the DUT outputs are compared to it.
module tb_obuf;
  localparam int DW = 8;
  localparam int N  = 5;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  obuf_if #(.datatype_size(DW), .fifo_length(N)) bus ();

  obuf #(.datatype_size(DW), .fifo_length(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Words not yet handed over, front = word currently owed.
  logic [DW-1:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_outputs(input string tag);
    logic busy;
    busy = (m_q.size() > 0);
    chk({tag, ".valid"},      32'(bus.o_valid),      32'(busy));
    chk({tag, ".load_ready"}, 32'(bus.o_load_ready), 32'(!busy));
    chk({tag, ".last"},       32'(bus.o_last),       32'(busy && m_q.size() == 1));
    if (busy) chk({tag, ".data"}, 32'(bus.o_data), 32'(m_q[0]));
  endtask

  // One clock: drive inputs, advance model at the edge, check at negedge.
  task automatic cycle(input logic ld, input vec_t d, input logic rdy, input string tag);
    bus.i_load  = ld;
    bus.i_data  = d;
    bus.i_ready = rdy;
    @(posedge clk);
    if (m_q.size() > 0) begin
      if (rdy) void'(m_q.pop_front());
    end else if (ld) begin
      for (int k = 0; k < N; k++) m_q.push_back(d[k]);
    end
    @(negedge clk);
    chk_outputs(tag);
  endtask

  task automatic reset_mid(input string tag);
    #2 rst_n = 1'b0;
    #1;
    m_q.delete();
    chk({tag, ".valid"},      32'(bus.o_valid),      32'd0);
    chk({tag, ".load_ready"}, 32'(bus.o_load_ready), 32'd1);
    chk({tag, ".data"},       32'(bus.o_data),       32'd0);
    chk({tag, ".last"},       32'(bus.o_last),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_outputs({tag, "_release"});
  endtask

  function automatic vec_t mkv(input int a, input int b, input int c, input int d, input int e);
    vec_t v;
    v[0] = DW'(a); v[1] = DW'(b); v[2] = DW'(c); v[3] = DW'(d); v[4] = DW'(e);
    return v;
  endfunction

  function automatic vec_t rndv();
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = DW'($urandom_range(0, 255));
    return v;
  endfunction

  initial begin
    vec_t        v15;
    vec_t        v9;
    logic [10:0] pat;

    v15 = mkv(1, 2, 3, 4, 5);
    v9  = mkv(9, 9, 9, 9, 9);
    bus.i_load  = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;

    // Reset values while rst_n is held from time zero.
    #12;
    chk("rst.valid",      32'(bus.o_valid),      32'd0);
    chk("rst.load_ready", 32'(bus.o_load_ready), 32'd1);
    chk("rst.data",       32'(bus.o_data),       32'd0);
    chk("rst.last",       32'(bus.o_last),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_outputs("post_rst");

    // Basic serialisation.
    cycle(1'b1, mkv(10, 20, 30, 40, 50), 1'b1, "basic");
    chk("basic.word0", 32'(bus.o_data), 32'd10);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, "basic");

    // Backpressure on word 3.
    cycle(1'b1, v15, 1'b1, "bp");
    cycle(1'b0, '0, 1'b1, "bp");
    cycle(1'b0, '0, 1'b1, "bp");
    chk("bp.shows3", 32'(bus.o_data), 32'd3);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, "bp_hold");
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "bp_resume");

    // Load while busy is ignored, then an idle load of 9s is taken.
    cycle(1'b1, v15, 1'b1, "busy");
    cycle(1'b1, v9, 1'b0, "busy_ld");
    for (int i = 0; i < 5; i++) cycle(1'b1, v9, 1'b1, "busy_ld");
    cycle(1'b1, v9, 1'b1, "nines");
    chk("nines.word0", 32'(bus.o_data), 32'd9);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, "nines");

    // Reset while word 2 is presented, then a fresh vector.
    cycle(1'b1, v15, 1'b1, "rmid");
    cycle(1'b0, '0, 1'b1, "rmid");
    cycle(1'b0, '0, 1'b1, "rmid");
    reset_mid("rmid_rst");
    cycle(1'b1, mkv(7, 8, 9, 10, 11), 1'b1, "after_rst");
    chk("after_rst.word0", 32'(bus.o_data), 32'd7);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, "after_rst");

    // Back-to-back vectors with i_load held high: 5 valid, 1 idle, 5 valid.
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, (i == 0) ? v15 : v9, 1'b1, "b2b");
      pat[10-i] = bus.o_valid;
    end
    chk("b2b.pattern", 32'(pat), 32'(11'b11111011111));
    cycle(1'b0, '0, 1'b1, "b2b_end");

    // Randomised traffic, including changing i_data and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) reset_mid("rnd_rst");
      cycle(1'($urandom_range(0, 2) == 0), rndv(), 1'($urandom_range(0, 3) != 0), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
